// File: rtl/ahb_mem_slv.sv
// AHB slave backed by a 2^ADDR_W x 32-bit register array, byte/halfword/word access, 2-cycle ERROR.
// Optional feature macro AHB_SLV_WAIT_EN: builds the WAIT state adding WAIT_CYCLES wait states per OKAY transfer.
module ahb_mem_slv #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_e;

  state_e            state_q;
  logic              ready_q;
  logic [1:0]        resp_q;
  logic              dphase_q;
  logic              write_q;
  logic [2:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       mem_q [2**ADDR_W];

  logic              take;
  logic              legal;
  logic              commit;
  logic [3:0]        be;
  logic              unused_inputs;

`ifdef AHB_SLV_WAIT_EN
  logic [3:0]        wait_q;
`else
  logic              unused_wait_cfg;
  assign unused_wait_cfg = (WAIT_CYCLES != 0);
`endif

  assign unused_inputs = ^{HBURST, HPROT, HTRANS[0], HADDR[31:ADDR_W+2]};

  // Only the completing data cycle (HREADYOUT high) can hand over to a new address phase.
  assign take = HSEL & HREADY & HTRANS[1] & ((state_q == ST_IDLE) | (state_q == ST_ERR2));

  always_comb begin
    case (HSIZE)
      HSIZE_BYTE: legal = 1'b1;
      HSIZE_HALF: legal = ~HADDR[0];
      HSIZE_WORD: legal = (HADDR[1:0] == 2'b00);
      default:    legal = 1'b0;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      resp_q   <= HRESP_OKAY;
      dphase_q <= 1'b0;
`ifdef AHB_SLV_WAIT_EN
      wait_q   <= 4'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_ERR2: begin
          dphase_q <= take & legal;
          if (take && !legal) begin
            state_q <= ST_ERR1;
            ready_q <= 1'b0;
            resp_q  <= HRESP_ERROR;
`ifdef AHB_SLV_WAIT_EN
          end else if (take && (WAIT_CYCLES != 0)) begin
            state_q <= ST_WAIT;
            ready_q <= 1'b0;
            resp_q  <= HRESP_OKAY;
            wait_q  <= 4'(WAIT_CYCLES - 1);
`endif
          end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            resp_q  <= HRESP_OKAY;
          end
        end
`ifdef AHB_SLV_WAIT_EN
        ST_WAIT: begin
          if (wait_q == 4'd0) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
`endif
        ST_ERR1: begin
          state_q <= ST_ERR2;
          ready_q <= 1'b1;
          resp_q  <= HRESP_ERROR;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          resp_q  <= HRESP_OKAY;
        end
      endcase
    end
  end

  // Data-phase control carries no reset: it is only observed while dphase_q is set.
  always_ff @(posedge HCLK) begin
    if (take) begin
      addr_q  <= HADDR[ADDR_W+1:0];
      write_q <= HWRITE;
      size_q  <= HSIZE;
    end
  end

  always_comb begin
    case (size_q)
      HSIZE_BYTE: be = 4'b0001 << addr_q[1:0];
      HSIZE_HALF: be = addr_q[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
  end

  assign commit = dphase_q & write_q & (state_q == ST_IDLE) & ~HRESET;

  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[addr_q[ADDR_W+1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HREADYOUT = ready_q;
  assign HRESP     = resp_q;
  assign HRDATA    = (dphase_q && !write_q) ? mem_q[addr_q[ADDR_W+1:2]] : 32'h0;

endmodule

// File: tb/tb_ahb_mem_slv.sv
// Bench for ahb_mem_slv: directed vector table, reset/wait corner sequence, randomized traffic vs. a memory model.
module tb_ahb_mem_slv;

  localparam int ADDR_W   = 8;
  localparam int WAIT_CYC = 2;
`ifdef AHB_SLV_WAIT_EN
  localparam int W = WAIT_CYC;
`else
  localparam int W = 0;
`endif
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = T_IDLE;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = '0;
  logic [2:0]  HBURST = '0;
  logic [3:0]  HPROT = '0;
  logic [31:0] HWDATA = '0;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  assign HREADY = HREADYOUT;

  ahb_mem_slv #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYC)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    bit        sel;
    bit [1:0]  trans;
    bit        wr;
    bit [2:0]  size;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit        exp_err;
    bit        chk_rd;
    bit [31:0] exp_rd;
  } vec_t;

  typedef struct {
    bit        rdy;
    bit [1:0]  resp;
    bit [31:0] rdata;
    bit        chk_rd;
  } exp_t;

  vec_t        dirq[$];
  vec_t        stimq[$];
  exp_t        expq[$];
  bit   [31:0] mdl [2**ADDR_W];
  bit   [31:0] pend_wdata = '0;
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic vec_t vec(bit sel, bit [1:0] trans, bit wr, bit [2:0] size, bit [31:0] addr,
                               bit [31:0] wdata, bit err, bit chk, bit [31:0] exp_rd);
    vec_t v;
    v.sel = sel; v.trans = trans; v.wr = wr; v.size = size; v.addr = addr;
    v.wdata = wdata; v.exp_err = err; v.chk_rd = chk; v.exp_rd = exp_rd;
    return v;
  endfunction

  function automatic exp_t mkexp(bit rdy, bit [1:0] resp, bit [31:0] rdata, bit chk);
    exp_t e;
    e.rdy = rdy; e.resp = resp; e.rdata = rdata; e.chk_rd = chk;
    return e;
  endfunction

  // Reference model: legality and byte-lane effects straight from the transfer rules.
  function automatic vec_t model_fill(vec_t v);
    int  sz  = int'(v.size);
    int  off = int'(v.addr[1:0]);
    int  wa  = int'(v.addr[ADDR_W+1:2]);
    bit  ok  = (sz == 0) || (sz == 1 && off % 2 == 0) || (sz == 2 && off == 0);
    v.exp_err = !ok;
    v.chk_rd  = 1'b1;
    v.exp_rd  = '0;
    if (v.sel && v.trans[1] && ok) begin
      if (v.wr) begin
        for (int b = off; b < off + (1 << sz); b++) mdl[wa][8*b +: 8] = v.wdata[8*b +: 8];
      end else begin
        v.exp_rd = mdl[wa];
      end
    end
    return v;
  endfunction

  function automatic void push_exp(vec_t v);
    bit [31:0] rd = v.wr ? 32'h0 : v.exp_rd;
    bit        ck = v.wr ? 1'b1 : v.chk_rd;
    if (!(v.sel && v.trans[1])) begin
      expq.push_back(mkexp(1'b1, 2'b00, 32'h0, 1'b1));
    end else if (v.exp_err) begin
      expq.push_back(mkexp(1'b0, 2'b01, 32'h0, 1'b1));
      expq.push_back(mkexp(1'b1, 2'b01, 32'h0, 1'b1));
    end else begin
      for (int i = 0; i < W; i++) expq.push_back(mkexp(1'b0, 2'b00, rd, ck));
      expq.push_back(mkexp(1'b1, 2'b00, rd, ck));
    end
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic drive(vec_t v);
    HWDATA = pend_wdata;
    HSEL   = v.sel;
    HTRANS = v.trans;
    HWRITE = v.wr;
    HSIZE  = v.size;
    HADDR  = v.addr;
    HBURST = 3'($urandom);
    HPROT  = 4'($urandom);
    pend_wdata = v.wdata;
  endtask

  task automatic check_cycle();
    exp_t e = mkexp(1'b1, 2'b00, 32'h0, 1'b1);
    if (expq.size() > 0) e = expq.pop_front();
    check("hreadyout", {31'b0, HREADYOUT}, {31'b0, e.rdy});
    check("hresp", {30'b0, HRESP}, {30'b0, e.resp});
    if (e.chk_rd) check("hrdata", HRDATA, e.rdata);
  endtask

  task automatic run_stim();
    int guard = 0;
    while ((stimq.size() > 0 || expq.size() > 0) && guard < 20000) begin
      @(negedge HCLK);
      guard++;
      check_cycle();
      if (HREADYOUT) begin
        if (stimq.size() > 0) begin
          vec_t v = stimq.pop_front();
          drive(v);
          push_exp(v);
        end else begin
          drive(vec(1'b0, T_IDLE, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0));
        end
      end
    end
    if (guard >= 20000) begin
      n_checks++;
      $display("FAIL run_stim: cycle budget expired, %0d expected cycles left", expq.size());
      stimq.delete();
      expq.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed table: {sel, trans, write, size, addr, wdata, exp_err, chk_rd, exp_rd}
    dirq.push_back(vec(1, T_NSEQ, 0, 3'd2, 32'h04,  32'h0,        0, 0, 32'h0));
    dirq.push_back(vec(1, T_IDLE, 0, 3'd2, 32'h04,  32'h0,        0, 1, 32'h0));
    dirq.push_back(vec(1, T_NSEQ, 1, 3'd2, 32'h10,  32'hDEADBEEF, 0, 1, 32'h0));
    dirq.push_back(vec(1, T_NSEQ, 1, 3'd0, 32'h12,  32'h00550000, 0, 1, 32'h0));
    dirq.push_back(vec(1, T_NSEQ, 0, 3'd2, 32'h10,  32'h0,        0, 1, 32'hDE55BEEF));
    dirq.push_back(vec(1, T_NSEQ, 1, 3'd2, 32'h20,  32'h12345678, 0, 1, 32'h0));
    dirq.push_back(vec(1, T_SEQ,  0, 3'd2, 32'h20,  32'h0,        0, 1, 32'h12345678));
    dirq.push_back(vec(1, T_NSEQ, 1, 3'd2, 32'h21,  32'hFFFFFFFF, 1, 1, 32'h0));
    dirq.push_back(vec(1, T_NSEQ, 0, 3'd2, 32'h20,  32'h0,        0, 1, 32'h12345678));
    dirq.push_back(vec(1, T_NSEQ, 1, 3'd2, 32'h04,  32'h11223344, 0, 1, 32'h0));
    dirq.push_back(vec(1, T_NSEQ, 1, 3'd1, 32'h06,  32'hABCD0000, 0, 1, 32'h0));
    dirq.push_back(vec(1, T_NSEQ, 0, 3'd1, 32'h06,  32'h0,        0, 1, 32'hABCD3344));
    dirq.push_back(vec(1, T_NSEQ, 0, 3'd3, 32'h08,  32'h0,        1, 1, 32'h0));
    dirq.push_back(vec(0, T_NSEQ, 1, 3'd2, 32'h10,  32'h0,        0, 1, 32'h0));
    dirq.push_back(vec(1, T_BUSY, 1, 3'd2, 32'h10,  32'h0,        0, 1, 32'h0));
    dirq.push_back(vec(1, T_NSEQ, 0, 3'd0, 32'h13,  32'h0,        0, 1, 32'hDE55BEEF));
    dirq.push_back(vec(1, T_NSEQ, 0, 3'd1, 32'h05,  32'h0,        1, 1, 32'h0));
    dirq.push_back(vec(1, T_NSEQ, 1, 3'd0, 32'h11,  32'h0000AA00, 0, 1, 32'h0));
    dirq.push_back(vec(1, T_NSEQ, 0, 3'd2, 32'h10,  32'h0,        0, 1, 32'hDE55AAEF));
    dirq.push_back(vec(1, T_NSEQ, 1, 3'd2, 32'h3FC, 32'hA5A55A5A, 0, 1, 32'h0));
    dirq.push_back(vec(1, T_NSEQ, 0, 3'd2, 32'h3FC, 32'h0,        0, 1, 32'hA5A55A5A));

    // Reset state
    repeat (2) @(negedge HCLK);
    check("reset_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    check("reset_hresp", {30'b0, HRESP}, 32'd0);
    check("reset_hrdata", HRDATA, 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;

    for (int i = 0; i < dirq.size(); i++) stimq.push_back(dirq[i]);
    run_stim();

    // Reset during a write's data phase (second wait cycle when waits are built)
    stimq.push_back(vec(1, T_NSEQ, 1, 3'd2, 32'h30, 32'hCAFEF00D, 0, 1, 32'h0));
    run_stim();
    @(negedge HCLK);
    drive(vec(1, T_NSEQ, 1, 3'd2, 32'h30, 32'h0BAD0BAD, 0, 1, 32'h0));
    for (int i = 1; i <= ((W == 0) ? 1 : W); i++) begin
      @(negedge HCLK);
      HWDATA = 32'h0BAD0BAD;
      check("rst_wr_hreadyout", {31'b0, HREADYOUT}, (W == 0) ? 32'd1 : 32'd0);
    end
    HRESET = 1'b1;
    drive(vec(0, T_IDLE, 0, 3'd0, 32'h0, 32'h0, 0, 1, 32'h0));
    #1;
    check("rst_mid_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    check("rst_mid_hresp", {30'b0, HRESP}, 32'd0);
    check("rst_mid_hrdata", HRDATA, 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;
    stimq.push_back(vec(1, T_NSEQ, 0, 3'd2, 32'h30, 32'h0, 0, 1, 32'hCAFEF00D));
    run_stim();

    // Randomized traffic against the model, in a region seeded with known words
    for (int i = 0; i < 16; i++) begin
      stimq.push_back(model_fill(vec(1, T_NSEQ, 1, 3'd2, 32'h100 + 32'(4 * i), $urandom, 0, 1, 32'h0)));
    end
    for (int i = 0; i < 300; i++) begin
      bit        sel  = ($urandom_range(0, 9) != 0);
      bit [1:0]  tr   = 2'($urandom_range(0, 3));
      bit        wr   = 1'($urandom_range(0, 1));
      bit [2:0]  sz   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      bit [31:0] addr = ($urandom & 32'hFFFFFC00) | (32'h100 + 32'($urandom_range(0, 63)));
      stimq.push_back(model_fill(vec(sel, tr, wr, sz, addr, $urandom, 0, 1, 32'h0)));
    end
    run_stim();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
